// File: rtl/mux_logic_unit.sv
// Two-input logic unit: each result bit is a 2:1 mux selected by b[i], with the mux data
// inputs chosen by op. Results are queued in a 2-entry FIFO with valid/ready on both sides.
module mux_logic_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero
);

    typedef enum logic [2:0] {
        OpAnd  = 3'b000,
        OpOr   = 3'b001,
        OpXor  = 3'b010,
        OpNand = 3'b011,
        OpNor  = 3'b100,
        OpXnor = 3'b101,
        OpNotA = 3'b110,
        OpPass = 3'b111
    } op_e;

    logic [WIDTH-1:0] w_sel_hi;
    logic [WIDTH-1:0] w_sel_lo;
    logic [WIDTH-1:0] w_result;
    logic             w_push;
    logic             w_pop;

    logic [WIDTH-1:0] r_data [2];
    logic             r_zero [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;

    // w_sel_hi feeds the mux where b[i]=1, w_sel_lo where b[i]=0
    always_comb begin
        w_sel_hi = a;
        w_sel_lo = a;
        unique case (op_e'(op))
            OpAnd:  begin w_sel_hi = a;         w_sel_lo = '0;        end
            OpOr:   begin w_sel_hi = '1;        w_sel_lo = a;         end
            OpXor:  begin w_sel_hi = ~a;        w_sel_lo = a;         end
            OpNand: begin w_sel_hi = ~a;        w_sel_lo = '1;        end
            OpNor:  begin w_sel_hi = '0;        w_sel_lo = ~a;        end
            OpXnor: begin w_sel_hi = a;         w_sel_lo = ~a;        end
            OpNotA: begin w_sel_hi = ~a;        w_sel_lo = ~a;        end
            OpPass: begin w_sel_hi = a;         w_sel_lo = a;         end
            default: begin w_sel_hi = a;        w_sel_lo = a;         end
        endcase
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_result[i] = b[i] ? w_sel_hi[i] : w_sel_lo[i];
        end
    end

    // in_ready depends only on registered occupancy, never on out_ready
    assign in_ready  = (r_count < 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign y    = out_valid ? r_data[r_rptr] : '0;
    assign zero = out_valid ? r_zero[r_rptr] : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_data[i] <= '0;
                r_zero[i] <= 1'b0;
            end
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_data[r_wptr] <= w_result;
                r_zero[r_wptr] <= ~|w_result;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

endmodule
